// File: rtl/stage1_fetch_if.sv
// rtl/stage1_fetch_if.sv - request, memory, IO and result signal bundle for stage1_fetch
interface stage1_fetch_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int SRC_WIDTH   = 8,
    parameter int IO_ID_WIDTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [1:0]             mblock_s1;
    logic [SRC_WIDTH-1:0]   vr_source;
    logic [ADDR_WIDTH-1:0]  ram_address;
    logic                   ram_read;
    logic [DATA_WIDTH-1:0]  ram_value;
    logic [IO_ID_WIDTH-1:0] io_device_id;
    logic                   io_read;
    logic                   io_valid;
    logic [DATA_WIDTH-1:0]  input_devices_value;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_WIDTH-1:0]  vr_value;
    logic                   out_error;

    modport slave (
        input  in_valid, mblock_s1, vr_source, ram_value, io_valid,
               input_devices_value, out_ready,
        output in_ready, ram_address, ram_read, io_device_id, io_read,
               out_valid, vr_value, out_error
    );

    modport master (
        output in_valid, mblock_s1, vr_source, ram_value, io_valid,
               input_devices_value, out_ready,
        input  in_ready, ram_address, ram_read, io_device_id, io_read,
               out_valid, vr_value, out_error
    );
endinterface

// File: rtl/stage1_fetch.sv
// rtl/stage1_fetch.sv - fetches one operand from RAM, an IO device or a constant per request
module stage1_fetch #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int SRC_WIDTH   = 8,
    parameter int IO_ID_WIDTH = 8,
    parameter int RAM_LATENCY = 1,
    parameter int IO_TIMEOUT  = 15
) (
    input  logic          clk,
    input  logic          reset_n,
    stage1_fetch_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RAM_WAIT, IO_WAIT, HOLD} state_t;

    localparam logic [1:0] MODE_RSV   = 2'd1;
    localparam logic [1:0] MODE_CONST = 2'd3;
    localparam int LAT_W = $clog2(RAM_LATENCY + 1) + 1;
    localparam int TMO_W = $clog2(IO_TIMEOUT + 1) + 1;

    state_t                state_q, state_d;
    logic                  in_ready_q, ram_read_q, io_read_q;
    logic                  out_valid_q, out_error_q;
    logic [DATA_WIDTH-1:0] vr_value_q;
    logic [SRC_WIDTH-1:0]  src_q;
    logic [1:0]            mode_q;
    logic [LAT_W-1:0]      lat_cnt;
    logic [TMO_W-1:0]      io_cnt;

    logic                  accept;
    logic                  ld_res;
    logic [DATA_WIDTH-1:0] res_data;
    logic                  res_err;

    assign accept = bus.in_valid && in_ready_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ld_res   = 1'b0;
        res_data = '0;
        res_err  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (bus.mblock_s1)
                        2'd0:    state_d = RAM_WAIT;
                        2'd2:    state_d = IO_WAIT;
                        default: state_d = HOLD;
                    endcase
                end
            end
            RAM_WAIT: begin
                if (lat_cnt == LAT_W'(RAM_LATENCY)) begin
                    state_d  = HOLD;
                    ld_res   = 1'b1;
                    res_data = bus.ram_value;
                end
            end
            IO_WAIT: begin
                // A late acknowledge on the timeout edge still delivers data.
                if (bus.io_valid) begin
                    state_d  = HOLD;
                    ld_res   = 1'b1;
                    res_data = bus.input_devices_value;
                end else if (io_cnt == TMO_W'(IO_TIMEOUT - 1)) begin
                    state_d = HOLD;
                    ld_res  = 1'b1;
                    res_err = 1'b1;
                end
            end
            HOLD: begin
                // Constant and reserved requests enter HOLD without a result yet.
                if (!out_valid_q) begin
                    ld_res   = 1'b1;
                    res_data = (mode_q == MODE_CONST) ? DATA_WIDTH'(src_q) : '0;
                    res_err  = (mode_q == MODE_RSV);
                end else if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            in_ready_q  <= 1'b0;
            ram_read_q  <= 1'b0;
            io_read_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_error_q <= 1'b0;
            vr_value_q  <= '0;
            src_q       <= '0;
            mode_q      <= '0;
            lat_cnt     <= '0;
            io_cnt      <= '0;
        end else begin
            in_ready_q <= (state_d == IDLE);
            io_read_q  <= (state_d == IO_WAIT);
            ram_read_q <= (state_q == IDLE) && (state_d == RAM_WAIT);
            if (accept) begin
                src_q   <= bus.vr_source;
                mode_q  <= bus.mblock_s1;
                lat_cnt <= '0;
                io_cnt  <= '0;
            end else begin
                if (state_q == RAM_WAIT) lat_cnt <= lat_cnt + 1'b1;
                if (state_q == IO_WAIT)  io_cnt  <= io_cnt + 1'b1;
            end
            if (ld_res) begin
                out_valid_q <= 1'b1;
                vr_value_q  <= res_data;
                out_error_q <= res_err;
            end else if (state_q == HOLD && state_d == IDLE) begin
                out_valid_q <= 1'b0;
                vr_value_q  <= '0;
                out_error_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.ram_read     = ram_read_q;
    assign bus.io_read      = io_read_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_error    = out_error_q;
    assign bus.vr_value     = vr_value_q;
    assign bus.ram_address  = (state_q != IDLE) ? ADDR_WIDTH'(src_q) : '0;
    assign bus.io_device_id = (state_q != IDLE) ? IO_ID_WIDTH'(src_q) : '0;
endmodule

// File: tb/tb_stage1_fetch.sv
// tb/tb_stage1_fetch.sv - directed self-checking bench for stage1_fetch
module tb_stage1_fetch;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   checks = 0;
    int   errors = 0;
    int   hi_cycles;

    always #5 clk = ~clk;

    stage1_fetch_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .SRC_WIDTH(8), .IO_ID_WIDTH(8)) ifa ();
    stage1_fetch_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .SRC_WIDTH(8), .IO_ID_WIDTH(8)) ifb ();

    stage1_fetch #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .SRC_WIDTH(8), .IO_ID_WIDTH(8),
                   .RAM_LATENCY(1), .IO_TIMEOUT(15))
        dut_a (.clk(clk), .reset_n(rst_a), .bus(ifa));

    stage1_fetch #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .SRC_WIDTH(8), .IO_ID_WIDTH(8),
                   .RAM_LATENCY(3), .IO_TIMEOUT(4))
        dut_b (.clk(clk), .reset_n(rst_b), .bus(ifb));

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a_idle(input string tag, input logic rdy);
        chk({tag, " in_ready"},   32'(ifa.in_ready), 32'(rdy));
        chk({tag, " ram_read"},   32'(ifa.ram_read), 0);
        chk({tag, " io_read"},    32'(ifa.io_read), 0);
        chk({tag, " out_valid"},  32'(ifa.out_valid), 0);
        chk({tag, " out_error"},  32'(ifa.out_error), 0);
        chk({tag, " vr_value"},   ifa.vr_value, 0);
        chk({tag, " ram_address"}, 32'(ifa.ram_address), 0);
        chk({tag, " io_device_id"}, 32'(ifa.io_device_id), 0);
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        ifa.in_valid = 0; ifa.mblock_s1 = 0; ifa.vr_source = 0; ifa.ram_value = 0;
        ifa.io_valid = 0; ifa.input_devices_value = 0; ifa.out_ready = 0;
        ifb.in_valid = 0; ifb.mblock_s1 = 0; ifb.vr_source = 0; ifb.ram_value = 32'hDEAD;
        ifb.io_valid = 0; ifb.input_devices_value = 0; ifb.out_ready = 0;

        // reset state
        tick(2);
        chk_a_idle("reset", 1'b0);
        chk("reset b in_ready", 32'(ifb.in_ready), 0);
        rst_a = 1'b1; rst_b = 1'b1;
        tick(1);
        chk("release a in_ready", 32'(ifa.in_ready), 1);
        chk("release b in_ready", 32'(ifb.in_ready), 1);

        // constant mode
        ifa.in_valid = 1; ifa.mblock_s1 = 3; ifa.vr_source = 33; ifa.out_ready = 1;
        tick(1);
        ifa.in_valid = 0; ifa.vr_source = 99; ifa.mblock_s1 = 0;
        chk("const T0 in_ready", 32'(ifa.in_ready), 0);
        chk("const T0 out_valid", 32'(ifa.out_valid), 0);
        chk("const T0 ram_read", 32'(ifa.ram_read), 0);
        chk("const T0 io_read", 32'(ifa.io_read), 0);
        tick(1);
        chk("const T1 out_valid", 32'(ifa.out_valid), 1);
        chk("const T1 vr_value", ifa.vr_value, 33);
        chk("const T1 out_error", 32'(ifa.out_error), 0);
        chk("const T1 ram_read", 32'(ifa.ram_read), 0);
        tick(1);
        chk_a_idle("const done", 1'b1);

        // backpressure
        ifa.in_valid = 1; ifa.mblock_s1 = 3; ifa.vr_source = 8'h5A; ifa.out_ready = 0;
        tick(1);
        ifa.in_valid = 0;
        tick(1);
        chk("bp T1 out_valid", 32'(ifa.out_valid), 1);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("bp hold vr_value", ifa.vr_value, 32'h5A);
            chk("bp hold out_valid", 32'(ifa.out_valid), 1);
            chk("bp hold in_ready", 32'(ifa.in_ready), 0);
        end
        ifa.out_ready = 1;
        tick(1);
        chk("bp release out_valid", 32'(ifa.out_valid), 0);
        chk("bp release in_ready", 32'(ifa.in_ready), 1);

        // reserved mode
        ifa.in_valid = 1; ifa.mblock_s1 = 1; ifa.vr_source = 7;
        tick(1);
        ifa.in_valid = 0;
        chk("rsv T0 ram_read", 32'(ifa.ram_read), 0);
        chk("rsv T0 io_read", 32'(ifa.io_read), 0);
        tick(1);
        chk("rsv T1 out_valid", 32'(ifa.out_valid), 1);
        chk("rsv T1 out_error", 32'(ifa.out_error), 1);
        chk("rsv T1 vr_value", ifa.vr_value, 0);
        chk("rsv T1 io_read", 32'(ifa.io_read), 0);
        tick(1);
        chk("rsv done out_error", 32'(ifa.out_error), 0);

        // IO with stall
        ifa.in_valid = 1; ifa.mblock_s1 = 2; ifa.vr_source = 33;
        ifa.input_devices_value = 32'd22;
        tick(1);
        ifa.in_valid = 0;
        hi_cycles = 0;
        chk("io T0 io_device_id", 32'(ifa.io_device_id), 33);
        if (ifa.io_read) hi_cycles++;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            chk("io stall out_valid", 32'(ifa.out_valid), 0);
            if (ifa.io_read) hi_cycles++;
        end
        ifa.io_valid = 1;
        tick(1);
        ifa.io_valid = 0;
        if (ifa.io_read) hi_cycles++;
        chk("io io_read cycles", 32'(hi_cycles), 6);
        chk("io out_valid", 32'(ifa.out_valid), 1);
        chk("io vr_value", ifa.vr_value, 22);
        chk("io out_error", 32'(ifa.out_error), 0);
        tick(1);
        chk("io done out_valid", 32'(ifa.out_valid), 0);

        // reset in the middle of an IO wait
        ifa.in_valid = 1; ifa.mblock_s1 = 2; ifa.vr_source = 8'h44;
        tick(1);
        ifa.in_valid = 0;
        tick(1);
        chk("rio wait io_read", 32'(ifa.io_read), 1);
        rst_a = 1'b0;
        tick(1);
        chk_a_idle("rio reset", 1'b0);
        rst_a = 1'b1; ifa.io_valid = 1; ifa.input_devices_value = 32'h77;
        tick(1);
        ifa.io_valid = 0;
        chk_a_idle("rio release", 1'b1);
        tick(1);
        chk_a_idle("rio after", 1'b1);

        // RAM with latency 3
        ifb.in_valid = 1; ifb.mblock_s1 = 0; ifb.vr_source = 33; ifb.out_ready = 1;
        tick(1);
        ifb.in_valid = 0; ifb.vr_source = 1;
        chk("ram T0 ram_read", 32'(ifb.ram_read), 1);
        chk("ram T0 ram_address", 32'(ifb.ram_address), 33);
        tick(1);
        chk("ram T1 ram_read", 32'(ifb.ram_read), 0);
        chk("ram T1 ram_address", 32'(ifb.ram_address), 33);
        tick(1);
        chk("ram T2 out_valid", 32'(ifb.out_valid), 0);
        tick(1);
        chk("ram T3 out_valid", 32'(ifb.out_valid), 0);
        ifb.ram_value = 32'd55;
        tick(1);
        ifb.ram_value = 32'hBAD;
        chk("ram T4 out_valid", 32'(ifb.out_valid), 1);
        chk("ram T4 vr_value", ifb.vr_value, 55);
        chk("ram T4 ram_read", 32'(ifb.ram_read), 0);
        tick(1);
        chk("ram done out_valid", 32'(ifb.out_valid), 0);
        chk("ram done ram_address", 32'(ifb.ram_address), 0);

        // IO timeout after 4 cycles
        ifb.in_valid = 1; ifb.mblock_s1 = 2; ifb.vr_source = 5;
        tick(1);
        ifb.in_valid = 0;
        tick(3);
        chk("tmo T3 io_read", 32'(ifb.io_read), 1);
        chk("tmo T3 out_valid", 32'(ifb.out_valid), 0);
        tick(1);
        chk("tmo T4 io_read", 32'(ifb.io_read), 0);
        chk("tmo T4 out_valid", 32'(ifb.out_valid), 1);
        chk("tmo T4 out_error", 32'(ifb.out_error), 1);
        chk("tmo T4 vr_value", ifb.vr_value, 0);
        tick(1);
        chk("tmo done in_ready", 32'(ifb.in_ready), 1);

        // acknowledge on the timeout edge wins
        ifb.in_valid = 1; ifb.mblock_s1 = 2; ifb.vr_source = 6;
        ifb.input_devices_value = 32'h99;
        tick(1);
        ifb.in_valid = 0;
        tick(3);
        ifb.io_valid = 1;
        tick(1);
        ifb.io_valid = 0;
        chk("edge T4 out_valid", 32'(ifb.out_valid), 1);
        chk("edge T4 out_error", 32'(ifb.out_error), 0);
        chk("edge T4 vr_value", ifb.vr_value, 32'h99);
        tick(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
